// File: rtl/count_seq_if.sv
// Control/load/status bundle between the count_seq wrapper and its user.
interface count_seq_if #(
    parameter int unsigned WIDTH = 16
);
    logic             preset;
    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH-1:0] ld_data;
    logic             start;
    logic             stop;
    logic             tick;
    logic             auto_reload;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic             tc_pulse;

    // Controller side: drives requests, observes status.
    modport master (
        output preset, ld_valid, ld_data, start, stop, tick, auto_reload,
        input  ld_ready, cnt, busy, done, tc_pulse
    );

    // Counter side.
    modport slave (
        input  preset, ld_valid, ld_data, start, stop, tick, auto_reload,
        output ld_ready, cnt, busy, done, tc_pulse
    );
endinterface

// File: rtl/count_seq.sv
// Loadable down-counter with reload register and IDLE/ARMED/RUN/DONE control.
// Every output is registered; status flags are derived from the next state.
module count_seq #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] PRESET_VAL = '1
) (
    input logic        clk,
    input logic        rst_n,
    count_seq_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q, tc_d;
    logic             busy_q, done_q, ld_ready_q;
    logic             ld_fire;

    // ld_ready_q already mirrors "state is not RUN", so no load is taken in RUN.
    assign ld_fire = bus.ld_valid && ld_ready_q;

    // Next-state: preset > load > stop > start > tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rld_d   = rld_q;
        tc_d    = 1'b0;
        if (bus.preset) begin
            cnt_d   = PRESET_VAL;
            state_d = S_IDLE;
        end else if (ld_fire) begin
            cnt_d   = bus.ld_data;
            rld_d   = bus.ld_data;
            state_d = S_ARMED;
        end else begin
            unique case (state_q)
                S_IDLE: ;
                S_ARMED: begin
                    if (bus.start) state_d = S_RUN;
                end
                S_RUN: begin
                    if (bus.stop) begin
                        state_d = S_ARMED;
                    end else if (bus.tick) begin
                        if (cnt_q == '0) begin
                            tc_d = 1'b1;
                            if (bus.auto_reload) begin
                                cnt_d = rld_q;
                            end else begin
                                cnt_d   = PRESET_VAL;
                                state_d = S_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q - WIDTH'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (bus.start) begin
                        cnt_d   = rld_q;
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= PRESET_VAL;
            rld_q      <= PRESET_VAL;
            tc_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ld_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rld_q      <= rld_d;
            tc_q       <= tc_d;
            busy_q     <= (state_d == S_RUN);
            done_q     <= (state_d == S_DONE);
            ld_ready_q <= (state_d != S_RUN);
        end
    end

    assign bus.cnt      = cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.tc_pulse = tc_q;
    assign bus.ld_ready = ld_ready_q;

endmodule

// File: tb/tb_count_seq.sv
// Directed bench for count_seq: load, count, auto-reload, stop/resume,
// priority collisions, DONE restart, zero load and async reset.
module tb_count_seq;

    localparam int unsigned WIDTH = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;

    count_seq_if #(.WIDTH(WIDTH)) bus ();

    count_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic status(input string tag, input logic [15:0] c, input logic b,
                          input logic d, input logic t, input logic r);
        chk({tag, ".cnt"},      32'(bus.cnt),      32'(c));
        chk({tag, ".busy"},     32'(bus.busy),     32'(b));
        chk({tag, ".done"},     32'(bus.done),     32'(d));
        chk({tag, ".tc"},       32'(bus.tc_pulse), 32'(t));
        chk({tag, ".ld_ready"}, 32'(bus.ld_ready), 32'(r));
    endtask

    task automatic load(input logic [15:0] v);
        bus.ld_valid = 1'b1;
        bus.ld_data  = v;
        cyc();
        bus.ld_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    logic [15:0] ar_cnt [9] = '{16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2, 16'd1, 16'd0, 16'd2};

    initial begin
        rst_n           = 1'b0;
        bus.preset      = 1'b0;
        bus.ld_valid    = 1'b0;
        bus.ld_data     = '0;
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.tick        = 1'b0;
        bus.auto_reload = 1'b0;
        repeat (3) cyc();
        status("rst", 16'hFFFF, 0, 0, 0, 1);
        rst_n = 1'b1;
        cyc();
        status("post_rst", 16'hFFFF, 0, 0, 0, 1);

        // IDLE ignores start and tick
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        status("idle_ign", 16'hFFFF, 0, 0, 0, 1);

        // Load 3 and count to terminal
        load(16'h0003);
        status("ld3", 16'h0003, 0, 0, 0, 1);
        pulse_start();
        status("start3", 16'h0003, 1, 0, 0, 0);
        bus.tick = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cyc();
            status($sformatf("dn%0d", i), 16'(3 - i), 1, 0, 0, 0);
        end
        cyc();
        status("dn_tc", 16'hFFFF, 0, 1, 1, 1);
        cyc();
        status("dn_5th", 16'hFFFF, 0, 1, 0, 1);
        bus.tick = 1'b0;

        // Auto-reload with tick held (load from DONE)
        bus.auto_reload = 1'b1;
        load(16'h0002);
        pulse_start();
        bus.tick = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            status($sformatf("ar%0d", i + 1), ar_cnt[i], 1, 0, 32'((i % 3) == 2), 0);
        end
        bus.tick        = 1'b0;
        bus.auto_reload = 1'b0;

        // Load request in RUN is refused
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h1234;
        cyc();
        bus.ld_valid = 1'b0;
        status("ld_in_run", 16'h0002, 1, 0, 0, 0);

        // Stop to ARMED, then stop/resume sequence
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        status("stop1", 16'h0002, 0, 0, 0, 1);
        load(16'h0010);
        pulse_start();
        bus.tick = 1'b1;
        repeat (4) cyc();
        chk("sr_4tick", 32'(bus.cnt), 32'h000C);
        bus.stop = 1'b1;
        cyc();
        bus.stop = 1'b0;
        status("sr_stop", 16'h000C, 0, 0, 0, 1);
        bus.tick = 1'b0;
        pulse_start();
        status("sr_resume", 16'h000C, 1, 0, 0, 0);
        bus.tick = 1'b1;
        repeat (12) cyc();
        status("sr_12", 16'h0000, 1, 0, 0, 0);
        cyc();
        status("sr_tc", 16'hFFFF, 0, 1, 1, 1);
        bus.tick = 1'b0;

        // DONE restart reloads rld
        pulse_start();
        status("done_rst", 16'h0010, 1, 0, 0, 0);

        // preset beats load in RUN
        bus.preset   = 1'b1;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h0055;
        cyc();
        bus.preset   = 1'b0;
        bus.ld_valid = 1'b0;
        status("preset", 16'hFFFF, 0, 0, 0, 1);

        // Load with start in ARMED: second load wins, stays ARMED
        load(16'h0007);
        bus.ld_valid = 1'b1;
        bus.ld_data  = 16'h0009;
        bus.start    = 1'b1;
        cyc();
        bus.ld_valid = 1'b0;
        bus.start    = 1'b0;
        status("ld_start", 16'h0009, 0, 0, 0, 1);
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        status("armed_tick", 16'h0009, 0, 0, 0, 1);

        // Zero load terminates on first tick
        load(16'h0000);
        pulse_start();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
        status("zero", 16'hFFFF, 0, 1, 1, 1);
        pulse_start();
        status("zero_restart", 16'h0000, 1, 0, 0, 0);

        // Async reset mid-RUN takes effect without a clock edge
        rst_n = 1'b0;
        #2;
        status("async_rst", 16'hFFFF, 0, 0, 0, 1);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
